// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC engine: default sizes,
// arctangent table in binary-angle units (2^15 LSB = pi) and the FSM state type.
package cordic_pkg;

    localparam int DW_DEFAULT   = 16;
    localparam int ITER_DEFAULT = 15;
    localparam int ATAN_LEN     = 16;

    // round(atan(2^-i) * 2^15 / pi)
    localparam int ATAN_TABLE [ATAN_LEN] = '{
        8192, 4836, 2555, 1297, 651, 326, 163, 81,
        41,   20,   10,   5,    3,   1,   1,   0
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cordic_microrot.sv
// Combinational single CORDIC micro-rotation: arithmetic shift by i, add/sub
// with wraparound, and angle update from the arctangent table.
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int dw = DW_DEFAULT,
    parameter int IW = 4
) (
    input  logic signed [dw-1:0] x,
    input  logic signed [dw-1:0] y,
    input  logic signed [dw-1:0] z,
    input  logic        [IW-1:0] i,
    input  logic                 d_pos,
    output logic signed [dw-1:0] x_next,
    output logic signed [dw-1:0] y_next,
    output logic signed [dw-1:0] z_next
);

    logic signed [dw-1:0] x_sh;
    logic signed [dw-1:0] y_sh;
    logic signed [dw-1:0] atan_val;

    always_comb begin
        x_sh     = x >>> i;
        y_sh     = y >>> i;
        atan_val = '0;
        if (int'(i) < ATAN_LEN) begin
            atan_val = dw'(ATAN_TABLE[i]);
        end
        if (d_pos) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan_val;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan_val;
        end
    end

endmodule

// File: rtl/cordic_mux2.sv
// 2:1 word select used for operand load (sel=0) versus register feedback (sel=1).
module cordic_mux2 #(
    parameter int W = 16
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC engine: loads X/Y/Z on start, runs ITER micro-rotations, pulses done.
// Optional vectoring mode (MODE port) is enabled by defining CORDIC_VECTOR_EN.
module cordic_iter_core
    import cordic_pkg::*;
#(
    parameter int dw   = DW_DEFAULT,
    parameter int ITER = ITER_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef CORDIC_VECTOR_EN
    input  logic          MODE,
`endif
    input  logic [dw-1:0] X_IN,
    input  logic [dw-1:0] Y_IN,
    input  logic [dw-1:0] Z_IN,
    output logic          sel,
    output logic [dw-1:0] X_OUT,
    output logic [dw-1:0] Y_OUT,
    output logic [dw-1:0] Z_OUT,
    output logic          busy,
    output logic          done
);

    localparam int IW = $clog2(dw);

    state_t               state_reg;
    logic        [IW-1:0] i_reg;
    logic signed [dw-1:0] x_reg, y_reg, z_reg;
    logic                 sel_reg, busy_reg, done_reg;
    logic signed [dw-1:0] x_rot, y_rot, z_rot;
    logic                 d_pos;
    logic        [dw-1:0] in_words  [3];
    logic        [dw-1:0] fb_words  [3];
    logic        [dw-1:0] sel_words [3];

`ifdef CORDIC_VECTOR_EN
    logic mode_reg;
    // Vectoring steers Y toward zero; rotation steers Z toward zero.
    assign d_pos = mode_reg ? y_reg[dw-1] : ~z_reg[dw-1];
`else
    assign d_pos = ~z_reg[dw-1];
`endif

    cordic_microrot #(
        .dw (dw),
        .IW (IW)
    ) u_microrot (
        .x      (x_reg),
        .y      (y_reg),
        .z      (z_reg),
        .i      (i_reg),
        .d_pos  (d_pos),
        .x_next (x_rot),
        .y_next (y_rot),
        .z_next (z_rot)
    );

    assign in_words[0] = X_IN;
    assign in_words[1] = Y_IN;
    assign in_words[2] = Z_IN;
    assign fb_words[0] = x_rot;
    assign fb_words[1] = y_rot;
    assign fb_words[2] = z_rot;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sel
            cordic_mux2 #(
                .W (dw)
            ) u_mux (
                .sel (sel_reg),
                .a   (in_words[gi]),
                .b   (fb_words[gi]),
                .y   (sel_words[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            i_reg     <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            sel_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef CORDIC_VECTOR_EN
            mode_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_RUN: begin
                    x_reg <= sel_words[0];
                    y_reg <= sel_words[1];
                    z_reg <= sel_words[2];
                    i_reg <= i_reg + IW'(1);
                    if (i_reg == IW'(ITER - 1)) begin
                        state_reg <= ST_DONE;
                        sel_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new load; sel is 0 so the muxes pass *_IN.
                    done_reg <= 1'b0;
                    if (start) begin
                        x_reg     <= sel_words[0];
                        y_reg     <= sel_words[1];
                        z_reg     <= sel_words[2];
                        i_reg     <= '0;
                        state_reg <= ST_RUN;
                        sel_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
`ifdef CORDIC_VECTOR_EN
                        mode_reg  <= MODE;
`endif
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign sel   = sel_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign X_OUT = x_reg;
    assign Y_OUT = y_reg;
    assign Z_OUT = z_reg;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Self-checking bench for cordic_iter_core: directed and random operations checked
// against an arithmetic CORDIC reference; covers CORDIC_VECTOR_EN when defined.
module tb_cordic_iter_core;

    localparam int DW   = 16;
    localparam int ITER = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic          sel, busy, done;
    logic [DW-1:0] x_out, y_out, z_out;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int atan_ref [16];
    int rx, ry, rz;

    always #5 clk = ~clk;

    cordic_iter_core #(.dw(DW), .ITER(ITER)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef CORDIC_VECTOR_EN
        .MODE  (mode),
`endif
        .X_IN  (x_in),
        .Y_IN  (y_in),
        .Z_IN  (z_in),
        .sel   (sel),
        .X_OUT (x_out),
        .Y_OUT (y_out),
        .Z_OUT (z_out),
        .busy  (busy),
        .done  (done)
    );

    function automatic int wrap16(input int v);
        shortint s;
        s = shortint'(v);
        return int'(s);
    endfunction

    function automatic int s16(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: textbook CORDIC loop on integers with 16-bit wraparound.
    task automatic model(input int x0, input int y0, input int z0, input bit vec,
                         output int xo, output int yo, output int zo);
        int x, y, z, xs, ys;
        bit dp;
        x = x0; y = y0; z = z0;
        for (int k = 0; k < ITER; k++) begin
            dp = vec ? (y < 0) : (z >= 0);
            xs = x >>> k;
            ys = y >>> k;
            if (dp) begin
                x = wrap16(x - ys); y = wrap16(y + xs); z = wrap16(z - atan_ref[k]);
            end else begin
                x = wrap16(x + ys); y = wrap16(y - xs); z = wrap16(z + atan_ref[k]);
            end
        end
        xo = x; yo = y; zo = z;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert (iabs(obs - exp) <= tol) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // One operation: start sampled at the next edge, then wait for done.
    // pa/pb: iteration edges at which start is pulsed; hold keeps start high throughout.
    task automatic run_op(input string tag, input int x0, input int y0, input int z0,
                          input bit vec, input int pa, input int pb, input bit hold);
        int ex, ey, ez, n, done_n, bad_win;
        model(x0, y0, z0, vec, ex, ey, ez);
        @(negedge clk);
        x_in = DW'(x0); y_in = DW'(y0); z_in = DW'(z0); mode = vec; start = 1'b1;
        @(posedge clk); #1;
        check({tag, "_load_x"}, s16(x_out), x0);
        check({tag, "_load_busy_sel"}, {30'd0, busy, sel}, 3);
        done_n = 0; bad_win = 0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = hold | (n == pa) | (n == pb);
            x_in = DW'($urandom); y_in = DW'($urandom); z_in = DW'($urandom);
            @(posedge clk); #1;
            if (done) begin
                done_n = n;
                break;
            end
            if (!busy || !sel) bad_win++;
        end
        check({tag, "_latency"}, done_n, ITER);
        check({tag, "_busy_window"}, bad_win, 0);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        check({tag, "_x"}, s16(x_out), ex);
        check({tag, "_y"}, s16(y_out), ey);
        check({tag, "_z"}, s16(z_out), ez);
        rx = s16(x_out); ry = s16(y_out); rz = s16(z_out);
        $display("op %s in=(%0d,%0d,%0d) out=(%0d,%0d,%0d) ref=(%0d,%0d,%0d)",
                 tag, x0, y0, z0, rx, ry, rz, ex, ey, ez);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk); #1;
            check({tag, "_post_idle"}, {30'd0, done, busy}, 0);
            check({tag, "_hold_x"}, s16(x_out), ex);
        end
    endtask

    initial begin
        int xr, yr, zr, saw_done;
        for (int k = 0; k < 16; k++)
            atan_ref[k] = int'($floor($atan(2.0 ** (-k)) * 32768.0 / 3.14159265358979 + 0.5));

        #12;
        check("reset_outs", s16(x_out) | s16(y_out) | s16(z_out), 0);
        check("reset_flags", {29'd0, sel, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("rot45", 9949, 0, 8192, 1'b0, 0, 0, 1'b0);
        check_tol("rot45_x_approx", rx, 11585, 4);
        check_tol("rot45_y_approx", ry, 11585, 4);
        check_tol("rot45_z_approx", rz, 0, 2);

        run_op("rotm90", 9949, 0, -16384, 1'b0, 0, 0, 1'b0);
        check_tol("rotm90_x_approx", rx, 0, 4);
        check_tol("rotm90_y_approx", ry, -16384, 4);

        run_op("ignore_start", 7000, -3000, 5000, 1'b0, 4, 11, 1'b0);

        // Back-to-back: start held high, each op loaded in the previous done cycle.
        for (int k = 0; k < 3; k++) begin
            xr = int'($urandom_range(0, 39718)) - 19859;
            yr = int'($urandom_range(0, 39718)) - 19859;
            zr = int'($urandom_range(0, 32768)) - 16384;
            run_op($sformatf("b2b%0d", k), xr, yr, zr, 1'b0, 0, 0, 1'b1);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;

        // Abort mid-operation with asynchronous reset.
        @(negedge clk);
        x_in = DW'(9949); y_in = '0; z_in = DW'(8192); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_outs_zero", iabs(s16(x_out)) + iabs(s16(y_out)) + iabs(s16(z_out)), 0);
        check("abort_flags", {29'd0, sel, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) saw_done++;
        end
        check("abort_no_done", saw_done, 0);
        $display("op abort at iteration 7: outputs cleared");

        run_op("after_abort", -5000, 12000, -9000, 1'b0, 0, 0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            xr = int'($urandom_range(0, 39718)) - 19859;
            yr = int'($urandom_range(0, 39718)) - 19859;
            zr = int'($urandom_range(0, 32768)) - 16384;
            run_op($sformatf("rand%0d", k), xr, yr, zr, 1'b0, 0, 0, 1'b0);
        end

`ifdef CORDIC_VECTOR_EN
        run_op("vec45", 9949, 9949, 0, 1'b1, 0, 0, 1'b0);
        check_tol("vec45_x_approx", rx, 23170, 6);
        check_tol("vec45_y_approx", ry, 0, 4);
        check_tol("vec45_z_approx", rz, 8192, 2);
        for (int k = 0; k < 2; k++) begin
            xr = int'($urandom_range(1, 13000));
            yr = int'($urandom_range(0, 26000)) - 13000;
            run_op($sformatf("vrand%0d", k), xr, yr, 0, 1'b1, 0, 0, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
